// File: rtl/bcd2bin_pkg.sv
// Shared encodings and constants for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;
   localparam int unsigned CORR_THRESH = 8;
   localparam int unsigned CORR_SUB    = 3;
   localparam int unsigned BCD_MAX     = 9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_CORRECT = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // True when a nibble is not a legal decimal digit.
   function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
      return d > BCD_DIGIT_W'(BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: subtract 3 from a digit that reached 8 or more.
module bcd_digit_adj
   import bcd2bin_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [BCD_DIGIT_W-1:0] adj_c
);

   always_comb begin
      adj_c = digit;
      if (digit >= BCD_DIGIT_W'(CORR_THRESH))
         adj_c = digit - BCD_DIGIT_W'(CORR_SUB);
   end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (shift right, then correct digits >= 8).
// Optional input digit check enabled by defining BCD2BIN_CHECK_EN.
module bcd2bin_seq
   import bcd2bin_pkg::*;
#(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned BIN_W  = 10
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_init,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] in_BCD,
   output logic                          out_BUSY,
   output logic                          out_DONE,
   output logic [BIN_W-1:0]              out_BIN,
   output logic                          out_ERR,
   output logic                          out_OVF
);

   localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int unsigned SR_W  = BCD_W + BIN_W;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   state_t            state, state_nxt;
   logic [SR_W-1:0]   sr, sr_nxt, sr_adj;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              check_fail;
   logic              last_correct;

   // Per-digit correction of the BCD half; the binary half passes through.
   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit (sr[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
         .adj_c (sr_adj[BIN_W + BCD_DIGIT_W*i +: BCD_DIGIT_W])
      );
   end
   assign sr_adj[BIN_W-1:0] = sr[BIN_W-1:0];

`ifdef BCD2BIN_CHECK_EN
   logic in_bad;
   always_comb begin
      in_bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++)
         in_bad = in_bad | digit_invalid(in_BCD[BCD_DIGIT_W*i +: BCD_DIGIT_W]);
   end
   assign check_fail = in_bad;
`else
   assign check_fail = 1'b0;
`endif

   assign last_correct = (state == ST_CORRECT) && (cnt == '0);

   // State, shift register and counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         sr    <= sr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (in_init) begin
               if (check_fail) begin
                  state_nxt = ST_DONE;
               end else begin
                  sr_nxt    = {in_BCD, BIN_W'(0)};
                  cnt_nxt   = CNT_W'(BIN_W);
                  state_nxt = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            sr_nxt    = sr >> 1;
            cnt_nxt   = cnt - CNT_W'(1);
            state_nxt = ST_CORRECT;
         end
         ST_CORRECT: begin
            sr_nxt    = sr_adj;
            state_nxt = (cnt == '0) ? ST_DONE : ST_SHIFT;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Handshake flags follow the next state; results load only on entry to DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_BUSY <= 1'b0;
         out_DONE <= 1'b0;
         out_BIN  <= '0;
         out_ERR  <= 1'b0;
         out_OVF  <= 1'b0;
      end else begin
         out_BUSY <= (state_nxt != ST_IDLE);
         out_DONE <= (state_nxt == ST_DONE);
         if (last_correct) begin
            out_BIN <= sr_adj[BIN_W-1:0];
            out_OVF <= |sr_adj[SR_W-1:BIN_W];
            out_ERR <= 1'b0;
         end else if ((state == ST_IDLE) && in_init && check_fail) begin
            out_BIN <= '0;
            out_OVF <= 1'b0;
            out_ERR <= 1'b1;
         end
      end
   end

`ifdef BENCH
   string state_name;
   always_comb state_name = state.name();
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed scoreboard bench for bcd2bin_seq: 3-digit/10-bit and 4-digit/12-bit instances.
module tb_bcd2bin_seq;

   typedef struct {
      int unsigned bin;
      int unsigned ovf;
      int unsigned err;
      int          done_cyc;
      bit          chk_bin;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        init3 = 1'b0, init4 = 1'b0;
   logic [11:0] bcd3 = '0;
   logic [15:0] bcd4 = '0;
   logic        busy3, done3, err3, ovf3;
   logic        busy4, done4, err4, ovf4;
   logic [9:0]  bin3;
   logic [11:0] bin4;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt3 = 0, done_cnt4 = 0;
   int   busy_low3 = 0;
   int   win_lo = -1, win_hi = -1;
   exp_t q3[$];
   exp_t q4[$];

   bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) u_dut3 (
      .clk(clk), .rst(rst), .in_init(init3), .in_BCD(bcd3),
      .out_BUSY(busy3), .out_DONE(done3), .out_BIN(bin3), .out_ERR(err3), .out_OVF(ovf3)
   );

   bcd2bin_seq #(.DIGITS(4), .BIN_W(12)) u_dut4 (
      .clk(clk), .rst(rst), .in_init(init4), .in_BCD(bcd4),
      .out_BUSY(busy4), .out_DONE(done4), .out_BIN(bin4), .out_ERR(err4), .out_OVF(ovf4)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard for the 3-digit instance.
   always @(negedge clk) begin
      if (cyc >= win_lo && cyc <= win_hi && busy3 === 1'b0) busy_low3++;
      if (done3 === 1'b1) begin
         exp_t e;
         done_cnt3++;
         check("dut3_done_expected", 32'(q3.size() != 0), 32'(1));
         if (q3.size() != 0) begin
            e = q3.pop_front();
            check("dut3_done_cycle", 32'(cyc), 32'(e.done_cyc));
            if (e.chk_bin) check("dut3_bin", 32'(bin3), 32'(e.bin));
            check("dut3_ovf", 32'(ovf3), 32'(e.ovf));
            check("dut3_err", 32'(err3), 32'(e.err));
            check("dut3_busy_in_done", 32'(busy3), 32'(1));
         end
      end
   end

   // Scoreboard for the 4-digit instance.
   always @(negedge clk) begin
      if (done4 === 1'b1) begin
         exp_t e;
         done_cnt4++;
         check("dut4_done_expected", 32'(q4.size() != 0), 32'(1));
         if (q4.size() != 0) begin
            e = q4.pop_front();
            check("dut4_done_cycle", 32'(cyc), 32'(e.done_cyc));
            check("dut4_bin", 32'(bin4), 32'(e.bin));
            check("dut4_ovf", 32'(ovf4), 32'(e.ovf));
            check("dut4_err", 32'(err4), 32'(0));
         end
      end
   end

   task automatic launch3(input logic [11:0] bcd, input int unsigned bin, input int unsigned ovf,
                          input int unsigned err, input int lat, input bit chk_bin);
      exp_t e;
      bcd3  = bcd;
      init3 = 1'b1;
      e.bin = bin; e.ovf = ovf; e.err = err; e.chk_bin = chk_bin;
      e.done_cyc = cyc + 1 + lat;
      q3.push_back(e);
      step(1);
      init3 = 1'b0;
      bcd3  = 12'hFFF;
   endtask

   task automatic launch4(input logic [15:0] bcd, input int unsigned bin, input int unsigned ovf);
      exp_t e;
      bcd4  = bcd;
      init4 = 1'b1;
      e.bin = bin; e.ovf = ovf; e.err = 0; e.chk_bin = 1'b1;
      e.done_cyc = cyc + 1 + 24;
      q4.push_back(e);
      step(1);
      init4 = 1'b0;
      bcd4  = 16'hFFFF;
   endtask

   task automatic wait_done3(input int target);
      int n = 0;
      while (done_cnt3 < target && n < 200) begin step(1); n++; end
      check("dut3_done_timeout", 32'(done_cnt3 >= target), 32'(1));
   endtask

   task automatic wait_done4(input int target);
      int n = 0;
      while (done_cnt4 < target && n < 200) begin step(1); n++; end
      check("dut4_done_timeout", 32'(done_cnt4 >= target), 32'(1));
   endtask

   initial begin
      int base;
      int snap;

      // Reset state.
      step(3);
      @(negedge clk);
      check("rst_busy3", 32'(busy3), 32'(0));
      check("rst_done3", 32'(done3), 32'(0));
      check("rst_bin3",  32'(bin3),  32'(0));
      check("rst_err3",  32'(err3),  32'(0));
      check("rst_ovf3",  32'(ovf3),  32'(0));
      check("rst_bin4",  32'(bin4),  32'(0));
      rst = 1'b1;
      step(2);

      // Full-range maximum; result held in IDLE afterwards.
      launch3(12'h999, 999, 0, 0, 20, 1'b1);
      check("busy_after_accept", 32'(busy3), 32'(1));
      wait_done3(1);
      step(5);
      check("hold_bin3", 32'(bin3), 32'(999));
      check("idle_busy3", 32'(busy3), 32'(0));

      // Zero, then a conversion with ignored mid-operation starts.
      launch3(12'h000, 0, 0, 0, 20, 1'b1);
      wait_done3(2);
      step(1);
      launch3(12'h256, 256, 0, 0, 20, 1'b1);
      step(1);
      init3 = 1'b1; step(1); init3 = 1'b0;
      step(6);
      init3 = 1'b1; step(1); init3 = 1'b0;
      wait_done3(3);
      step(30);
      check("single_done_256", 32'(done_cnt3), 32'(3));

      // Invalid digit.
`ifdef BCD2BIN_CHECK_EN
      launch3(12'h1A5, 0, 0, 1, 0, 1'b1);
`else
      launch3(12'h1A5, 0, 0, 0, 20, 1'b0);
`endif
      wait_done3(4);
      step(2);

      // Held start: back-to-back conversions every 22 cycles.
      bcd3  = 12'h042;
      init3 = 1'b1;
      base  = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         exp_t e;
         e.bin = 42; e.ovf = 0; e.err = 0; e.chk_bin = 1'b1;
         e.done_cyc = base + 22*k + 20;
         q3.push_back(e);
      end
      win_lo = base;
      win_hi = base + 64;
      step(45);
      init3 = 1'b0;
      wait_done3(7);
      step(3);
      check("held_busy_low_cycles", 32'(busy_low3), 32'(2));
      check("held_done_count", 32'(done_cnt3), 32'(7));

      // Reset mid-conversion: nothing resumes.
      bcd3  = 12'h123;
      init3 = 1'b1;
      step(1);
      init3 = 1'b0;
      step(6);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy3", 32'(busy3), 32'(0));
      check("midrst_bin3",  32'(bin3),  32'(0));
      check("midrst_done3", 32'(done3), 32'(0));
      step(2);
      rst = 1'b1;
      snap = done_cnt3;
      step(40);
      check("midrst_no_done", 32'(done_cnt3), 32'(snap));
      check("midrst_idle_busy3", 32'(busy3), 32'(0));
      check("midrst_idle_bin3",  32'(bin3),  32'(0));
      check("midrst_idle_ovf3",  32'(ovf3),  32'(0));

      // Wider instance: overflow and in-range boundary.
      launch4(16'h5000, 904, 1);
      wait_done4(1);
      step(1);
      launch4(16'h4095, 4095, 0);
      wait_done4(2);
      step(1);
      launch4(16'h9999, 1807, 1);
      wait_done4(3);
      step(4);
      check("hold_bin4", 32'(bin4), 32'(1807));

      check("q3_drained", 32'(q3.size()), 32'(0));
      check("q4_drained", 32'(q4.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
